// File: rtl/xfer_pkg.sv
// Shared definitions for the transfer engine: state encoding and default geometry.
package xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } xfer_state_e;

    localparam int XFER_ADDR_W   = 8;
    localparam int XFER_MAX_WAIT = 4;
    localparam int XFER_WAIT_W   = 4;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [XFER_WAIT_W-1:0] sat_inc(
        input logic [XFER_WAIT_W-1:0] val,
        input logic [XFER_WAIT_W-1:0] ceil
    );
        if (val >= ceil) begin
            sat_inc = ceil;
        end else begin
            sat_inc = val + {{(XFER_WAIT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/xfer_wait_timer.sv
// Counts consecutive target stalls and raises a registered dly flag once the
// run reaches MAX_WAIT; an accepted beat or a new transfer clears both.
module xfer_wait_timer
    import xfer_pkg::*;
#(
    parameter int MAX_WAIT = XFER_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic dly
);

    localparam logic [XFER_WAIT_W-1:0] MAX_W = XFER_WAIT_W'(MAX_WAIT);

    logic [XFER_WAIT_W-1:0] cnt_q;
    logic [XFER_WAIT_W-1:0] cnt_d;
    logic                   dly_q;
    logic                   dly_d;

    // Next stall count and flag.
    always_comb begin
        cnt_d = cnt_q;
        dly_d = dly_q;
        if (clear) begin
            cnt_d = {XFER_WAIT_W{1'b0}};
            dly_d = 1'b0;
        end else if (count_en) begin
            cnt_d = sat_inc(cnt_q, MAX_W);
            dly_d = (cnt_d == MAX_W);
        end else begin
            cnt_d = cnt_q;
            dly_d = dly_q;
        end
    end

    // Stall counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {XFER_WAIT_W{1'b0}};
            dly_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dly_q <= dly_d;
        end
    end

    assign dly = dly_q;

endmodule

// File: rtl/xfer_engine.sv
// Burst transfer engine: on a grant, issues len+1 address-incrementing beats
// to a target that may stall, then pulses done and returns to idle.
module xfer_engine
    import xfer_pkg::*;
#(
    parameter int ADDR_W   = XFER_ADDR_W,
    parameter int MAX_WAIT = XFER_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt,
    input  logic [3:0]        len,
    input  logic [ADDR_W-1:0] base,
    input  logic              tgt_rdy,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              busy,
    output logic              dly,
    output logic              done
);

    xfer_state_e       state_q;
    xfer_state_e       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              done_q;
    logic              done_d;
    logic              wt_en_s;
    logic              wt_clear_s;

    // Next-state, beat counter and address sequencing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        wt_en_s    = 1'b0;
        wt_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    state_d    = ST_XFER;
                    addr_d     = base;
                    cnt_d      = len;
                    wt_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (tgt_rdy) begin
                    addr_d     = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    wt_clear_s = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    wt_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address, beat counter and done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    xfer_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en (wt_en_s),
        .clear    (wt_clear_s),
        .dly      (dly)
    );

    // wr_en follows tgt_rdy combinationally so a beat is issued in the cycle it is accepted.
    assign wr_en = (state_q == ST_XFER) & tgt_rdy;
    assign busy  = (state_q != ST_IDLE);
    assign addr  = addr_q;
    assign done  = done_q;

endmodule

// File: doc/xfer_engine.md
XFER_ENGINE -- requirements
Module: xfer_engine

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter MAX_WAIT, default 4, consecutive not-ready cycles before dly asserts (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 gnt  input  1  grant from the request/grant FSM; starts a transfer when IDLE.
REQ-006 len  input  4  beat count minus one, sampled with gnt (1..16 beats).
REQ-007 base  input  ADDR_W  start address, sampled with gnt.
REQ-008 tgt_rdy  input  1  target accepts a beat this cycle.
REQ-009 addr  output  ADDR_W  current beat address, registered.
REQ-010 wr_en  output  1  beat issued this cycle; equals (state==XFER) & tgt_rdy.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 dly  output  1  target-stall indication back to the FSM, registered.
REQ-013 done  output  1  one-cycle completion pulse back to the FSM, registered.

Function
REQ-014 States SHALL be IDLE, XFER, DONE; no other reachable states.
REQ-015 IDLE: gnt=1 at clock edge -> load addr<=base, beat counter<=len, wait counter<=0, go XFER; busy rises the following cycle.
REQ-016 XFER with tgt_rdy=1: wr_en=1 that cycle; at edge addr<=addr+1, counter decrements, wait counter<=0, dly<=0.
REQ-017 XFER with tgt_rdy=1 and counter==0 (last beat): go DONE; addr still increments.
REQ-018 XFER with tgt_rdy=0: wr_en=0, addr and counter hold, wait counter increments saturating at MAX_WAIT.
REQ-019 dly SHALL be 1 from the edge on which wait counter reaches MAX_WAIT until the edge after the next accepted beat.
REQ-020 DONE: done=1 for exactly one cycle, busy=1, then IDLE unconditionally.
REQ-021 gnt SHALL be ignored in XFER and DONE; gnt dropping mid-transfer does not abort it.
REQ-022 gnt=1 held continuously SHALL start a new transfer on the first IDLE cycle after DONE (one idle cycle between transfers).
REQ-023 addr SHALL wrap modulo 2^ADDR_W (0xFF+1 -> 0x00 for ADDR_W=8) with no flag.
REQ-024 Beats issued per transfer SHALL equal len+1 exactly, regardless of stall count.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, addr=0, counters=0, wr_en=0, busy=0, dly=0, done=0, including mid-transfer.
REQ-026 First transfer after rst deassertion requires a fresh gnt sampled in IDLE; no partial transfer resumes.

Structure
REQ-027 Package xfer_pkg SHALL hold the state encoding typedef and the ADDR_W/MAX_WAIT defaults.
REQ-028 Stall counting and dly generation SHALL be one sub-module, xfer_wait_timer (inputs: clk, rst, count_en, clear; output: dly).

Verification
REQ-029 rst=1 mid-XFER (len=7, after 3 beats) -> all outputs 0 same cycle; IDLE after release.
REQ-030 gnt pulse, len=3, base=0x10, tgt_rdy=1 -> wr_en 4 cycles at addr 0x10..0x13, done pulse next cycle, busy 5 cycles.
REQ-031 len=1, tgt_rdy=0 for 6 cycles mid-transfer -> dly high after 4th stall cycle, low after next beat; 2 beats total.
REQ-032 base=0xFE, len=3 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-033 gnt held high, len=0 -> single-beat transfers each separated by DONE plus one IDLE cycle.
REQ-034 gnt toggled during XFER (len=5) -> exactly 6 beats, no restart, single done pulse.
